// File: rtl/eth_mac_tx.sv
// rtl/eth_mac_tx.sv - Ethernet MAC transmit framer: preamble, SFD, payload, pad, FCS, IFG
// Byte-slot driven: everything advances only when rgmii_mac_tx_rdy grants a slot.

module eth_mac_tx_crc8 (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    crc_out = c;
  end
endmodule

module eth_mac_tx #(
  parameter int MIN_FRAME_LEN = 60,
  parameter int IFG_BYTES     = 12,
  parameter int PREAMBLE_LEN  = 7
) (
  input  logic       clk_125,
  input  logic       reset_n,
  input  logic [7:0] s_tx_tdata,
  input  logic       s_tx_tvalid,
  input  logic       s_tx_tlast,
  input  logic       s_tx_tuser,
  output logic       s_tx_tready,
  output logic [7:0] rgmii_mac_tx_data,
  output logic       rgmii_mac_tx_dv,
  output logic       rgmii_mac_tx_er,
  input  logic       rgmii_mac_tx_rdy,
  output logic       tx_busy,
  output logic       tx_frame_done,
  output logic       tx_underrun
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, DRAIN, IFG} state_t;

  localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_LEN);
  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [15:0] byte_cnt, byte_cnt_nxt, byte_cnt_inc;
  logic [31:0] crc, crc_nxt, crc_upd, fcs;
  logic [7:0]  crc_in;
  logic [7:0]  data_nxt;
  logic        dv_nxt, er_nxt, done_nxt, unf_nxt;
  logic        drain_last, drain_last_nxt;
  logic        accept;

  // DRAIN stops accepting once tlast is taken so the next frame is not swallowed
  // while waiting for the slot that moves the FSM on.
  assign s_tx_tready  = reset_n && (((state == PAYLOAD) && rgmii_mac_tx_rdy) ||
                                    ((state == DRAIN) && !drain_last));
  assign accept       = s_tx_tvalid && s_tx_tready;
  assign tx_busy      = (state != IDLE);
  assign byte_cnt_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
  assign crc_in       = (state == PAD) ? 8'h00 : s_tx_tdata;
  assign fcs          = ~crc;

  eth_mac_tx_crc8 u_crc (
    .crc_in  (crc),
    .data    (crc_in),
    .crc_out (crc_upd)
  );

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    byte_cnt_nxt   = byte_cnt;
    crc_nxt        = crc;
    data_nxt       = rgmii_mac_tx_data;
    dv_nxt         = rgmii_mac_tx_dv;
    er_nxt         = rgmii_mac_tx_er;
    done_nxt       = 1'b0;
    unf_nxt        = 1'b0;
    drain_last_nxt = drain_last;
    if ((state == DRAIN) && accept && s_tx_tlast)
      drain_last_nxt = 1'b1;
    if (rgmii_mac_tx_rdy) begin
      data_nxt = 8'h00;
      dv_nxt   = 1'b0;
      er_nxt   = 1'b0;
      case (state)
        IDLE: begin
          if (s_tx_tvalid) begin
            data_nxt  = 8'h55;
            dv_nxt    = 1'b1;
            cnt_nxt   = 8'd1;
            state_nxt = PREAMBLE;
          end
        end
        PREAMBLE: begin
          data_nxt = 8'h55;
          dv_nxt   = 1'b1;
          if (cnt == PRE_LAST) state_nxt = SFD;
          else                 cnt_nxt   = cnt + 8'd1;
        end
        SFD: begin
          data_nxt     = 8'hD5;
          dv_nxt       = 1'b1;
          crc_nxt      = 32'hFFFFFFFF;
          byte_cnt_nxt = 16'd0;
          state_nxt    = PAYLOAD;
        end
        PAYLOAD: begin
          dv_nxt = 1'b1;
          if (s_tx_tvalid) begin
            data_nxt     = s_tx_tdata;
            er_nxt       = s_tx_tlast && s_tx_tuser;
            crc_nxt      = crc_upd;
            byte_cnt_nxt = byte_cnt_inc;
            if (s_tx_tlast) begin
              cnt_nxt   = 8'd0;
              state_nxt = (byte_cnt_inc < MIN_LEN) ? PAD : FCS;
            end
          end else begin
            er_nxt         = 1'b1;
            unf_nxt        = 1'b1;
            drain_last_nxt = 1'b0;
            state_nxt      = DRAIN;
          end
        end
        PAD: begin
          dv_nxt       = 1'b1;
          crc_nxt      = crc_upd;
          byte_cnt_nxt = byte_cnt_inc;
          if (byte_cnt_inc >= MIN_LEN) begin
            cnt_nxt   = 8'd0;
            state_nxt = FCS;
          end
        end
        FCS: begin
          data_nxt = fcs[{cnt[1:0], 3'b000} +: 8];
          dv_nxt   = 1'b1;
          if (cnt[1:0] == 2'd3) begin
            done_nxt  = 1'b1;
            cnt_nxt   = 8'd0;
            state_nxt = IFG;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        DRAIN: begin
          if (drain_last || (accept && s_tx_tlast)) begin
            drain_last_nxt = 1'b0;
            cnt_nxt        = 8'd0;
            state_nxt      = IFG;
          end
        end
        IFG: begin
          if (cnt == IFG_LAST) state_nxt = IDLE;
          else                 cnt_nxt   = cnt + 8'd1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_125) begin
    if (!reset_n) begin
      state             <= IDLE;
      cnt               <= 8'd0;
      byte_cnt          <= 16'd0;
      crc               <= 32'hFFFFFFFF;
      drain_last        <= 1'b0;
      rgmii_mac_tx_data <= 8'h00;
      rgmii_mac_tx_dv   <= 1'b0;
      rgmii_mac_tx_er   <= 1'b0;
      tx_frame_done     <= 1'b0;
      tx_underrun       <= 1'b0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      byte_cnt          <= byte_cnt_nxt;
      crc               <= crc_nxt;
      drain_last        <= drain_last_nxt;
      rgmii_mac_tx_data <= data_nxt;
      rgmii_mac_tx_dv   <= dv_nxt;
      rgmii_mac_tx_er   <= er_nxt;
      tx_frame_done     <= done_nxt;
      tx_underrun       <= unf_nxt;
    end
  end
endmodule

// File: tb/tb_eth_mac_tx.sv
// tb/tb_eth_mac_tx.sv - scoreboard bench for eth_mac_tx
// Expected wire slots are queued from the stimulus; a negedge monitor queues observed slots.

module tb_eth_mac_tx;
  localparam int MIN_LEN = 60;
  localparam int IFG     = 12;
  localparam int PRE     = 7;

  logic       clk_125 = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] s_tx_tdata = 8'h00;
  logic       s_tx_tvalid = 1'b0, s_tx_tlast = 1'b0, s_tx_tuser = 1'b0;
  logic       s_tx_tready;
  logic [7:0] rgmii_mac_tx_data;
  logic       rgmii_mac_tx_dv, rgmii_mac_tx_er;
  logic       rgmii_mac_tx_rdy = 1'b1;
  logic       tx_busy, tx_frame_done, tx_underrun;

  always #4 clk_125 = ~clk_125;

  eth_mac_tx #(.MIN_FRAME_LEN(MIN_LEN), .IFG_BYTES(IFG), .PREAMBLE_LEN(PRE)) dut (
    .clk_125           (clk_125),
    .reset_n           (reset_n),
    .s_tx_tdata        (s_tx_tdata),
    .s_tx_tvalid       (s_tx_tvalid),
    .s_tx_tlast        (s_tx_tlast),
    .s_tx_tuser        (s_tx_tuser),
    .s_tx_tready       (s_tx_tready),
    .rgmii_mac_tx_data (rgmii_mac_tx_data),
    .rgmii_mac_tx_dv   (rgmii_mac_tx_dv),
    .rgmii_mac_tx_er   (rgmii_mac_tx_er),
    .rgmii_mac_tx_rdy  (rgmii_mac_tx_rdy),
    .tx_busy           (tx_busy),
    .tx_frame_done     (tx_frame_done),
    .tx_underrun       (tx_underrun)
  );

  typedef struct packed {
    logic       dv;
    logic       er;
    logic [7:0] data;
    logic       done;
    logic       unf;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   rdy_div = 1, rdy_ph = 0;
  bit   cap = 1'b0;
  int   hold_viol = 0, tready_cnt = 0, tready_norrdy = 0;
  logic slot_q = 1'b0;
  logic [9:0] prev_out = '0;

  function automatic rec_t mk(input logic dv, input logic er, input logic [7:0] d,
                              input logic done, input logic unf);
    rec_t r;
    r.dv = dv; r.er = er; r.data = d; r.done = done; r.unf = unf;
    return r;
  endfunction

  // Bit-serial CRC-32 (reflected 0xEDB88320), one data bit per step.
  function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk_125); #1;
    rdy_ph = (rdy_ph + 1) % rdy_div;
    rgmii_mac_tx_rdy = (rdy_ph == 0);
  end

  initial forever begin
    rec_t r;
    @(negedge clk_125);
    r = mk(rgmii_mac_tx_dv, rgmii_mac_tx_er, rgmii_mac_tx_data, tx_frame_done, tx_underrun);
    if (cap) begin
      if (slot_q) begin
        if (r.dv || obs_q.size() > 0) obs_q.push_back(r);
      end else if (r[11:2] !== prev_out) begin
        hold_viol++;
      end
      if (s_tx_tready) tready_cnt++;
      if (s_tx_tready && !rgmii_mac_tx_rdy) tready_norrdy++;
    end
    prev_out = r[11:2];
    slot_q   = rgmii_mac_tx_rdy || !reset_n;
  end

  task automatic push_frame(input int len, input logic [7:0] base, input bit bad);
    logic [31:0] c = 32'hFFFFFFFF;
    int          tot = (len < MIN_LEN) ? MIN_LEN : len;
    logic [7:0]  d;
    for (int k = 0; k < PRE; k++) exp_q.push_back(mk(1'b1, 1'b0, 8'h55, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 8'hD5, 1'b0, 1'b0));
    for (int k = 0; k < tot; k++) begin
      d = (k < len) ? 8'(base + k) : 8'h00;
      c = model_crc(c, d);
      exp_q.push_back(mk(1'b1, bad && (k == len - 1), d, 1'b0, 1'b0));
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(1'b1, 1'b0, c[8*k +: 8], k == 3, 1'b0));
    for (int k = 0; k < IFG; k++) exp_q.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
  endtask

  task automatic send_frame(input int len, input logic [7:0] base, input bit bad,
                            input int stall_at, input int abort_at);
    int i = 0, guard = 0, stall = (stall_at >= 0) ? 3 : 0;
    bit acc;
    while (i < len && i != abort_at && guard < 5000) begin
      if (i == stall_at && stall > 0) begin
        s_tx_tvalid = 1'b0;
        stall--;
      end else begin
        s_tx_tvalid = 1'b1;
        s_tx_tdata  = 8'(base + i);
        s_tx_tlast  = (i == len - 1);
        s_tx_tuser  = bad && (i == len - 1);
      end
      @(negedge clk_125);
      acc = s_tx_tvalid && s_tx_tready;
      @(posedge clk_125); #1;
      if (acc) i++;
      guard++;
    end
    s_tx_tvalid = 1'b0; s_tx_tlast = 1'b0; s_tx_tuser = 1'b0;
    if (guard >= 5000) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: accepted %0d of %0d bytes", i, len);
    end
  endtask

  task automatic wait_obs(input int n, output bit ok);
    int g = 0;
    while (obs_q.size() < n && g < 20000) begin
      @(negedge clk_125);
      g++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (tx_busy && g < 2000) begin
      @(negedge clk_125);
      g++;
    end
    @(posedge clk_125); #1;
  endtask

  task automatic start_capture();
    obs_q.delete(); exp_q.delete();
    hold_viol = 0; tready_cnt = 0; tready_norrdy = 0;
    cap = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_125);
    @(negedge clk_125);
    n_cmp++; if (rgmii_mac_tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", rgmii_mac_tx_data); end
    n_cmp++; if (rgmii_mac_tx_dv !== 1'b0) begin n_bad++; $display("FAIL rst_dv: got %b want 0", rgmii_mac_tx_dv); end
    n_cmp++; if (rgmii_mac_tx_er !== 1'b0) begin n_bad++; $display("FAIL rst_er: got %b want 0", rgmii_mac_tx_er); end
    n_cmp++; if (s_tx_tready !== 1'b0) begin n_bad++; $display("FAIL rst_tready: got %b want 0", s_tx_tready); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", tx_busy); end
    n_cmp++; if (tx_frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", tx_frame_done); end
    n_cmp++; if (tx_underrun !== 1'b0) begin n_bad++; $display("FAIL rst_underrun: got %b want 0", tx_underrun); end
    @(posedge clk_125); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk_125); #1;
  endtask

  task automatic test_frame60();
    bit ok; rec_t e, o; logic [31:0] res = 32'hFFFFFFFF;
    start_capture();
    push_frame(60, 8'h00, 1'b0);
    send_frame(60, 8'h00, 1'b0, -1, -1);
    wait_obs(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL f60_timeout: got %0d slots want %0d", obs_q.size(), exp_q.size()); end
    else for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (k >= 8 && k < 72) res = model_crc(res, o.data);
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL f60_slot%0d: got %h want %h", k, o, e); end
    end
    n_cmp++;
    if (res !== 32'hDEBB20E3) begin n_bad++; $display("FAIL f60_residue: got %h want debb20e3", res); end
    cap = 1'b0;
    wait_idle();
  endtask

  task automatic test_pad();
    bit ok; rec_t e, o;
    start_capture();
    push_frame(10, 8'hA0, 1'b0);
    send_frame(10, 8'hA0, 1'b0, -1, -1);
    wait_obs(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL pad_timeout: got %0d slots want %0d", obs_q.size(), exp_q.size()); end
    else for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL pad_slot%0d: got %h want %h", k, o, e); end
    end
    n_cmp++;
    if (tready_cnt !== 10) begin n_bad++; $display("FAIL pad_tready_cycles: got %0d want 10", tready_cnt); end
    cap = 1'b0;
    wait_idle();
  endtask

  task automatic test_slow();
    bit ok; rec_t e, o;
    rdy_div = 5;
    repeat (6) @(posedge clk_125); #1;
    start_capture();
    push_frame(64, 8'h00, 1'b0);
    send_frame(64, 8'h00, 1'b0, -1, -1);
    wait_obs(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL slow_timeout: got %0d slots want %0d", obs_q.size(), exp_q.size()); end
    else for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL slow_slot%0d: got %h want %h", k, o, e); end
    end
    n_cmp++;
    if (hold_viol !== 0) begin n_bad++; $display("FAIL slow_hold: got %0d changes between slots want 0", hold_viol); end
    n_cmp++;
    if (tready_norrdy !== 0) begin n_bad++; $display("FAIL slow_tready_without_rdy: got %0d want 0", tready_norrdy); end
    cap = 1'b0;
    wait_idle();
    rdy_div = 1;
    repeat (6) @(posedge clk_125); #1;
  endtask

  task automatic test_underrun();
    bit ok; rec_t e, o; int n_busy = 0, g = 0, n_dv = 0;
    start_capture();
    for (int k = 0; k < PRE; k++) exp_q.push_back(mk(1'b1, 1'b0, 8'h55, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 8'hD5, 1'b0, 1'b0));
    for (int k = 0; k < 20; k++) exp_q.push_back(mk(1'b1, 1'b0, 8'(8'h30 + k), 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b1, 8'h00, 1'b0, 1'b1));
    send_frame(100, 8'h30, 1'b0, 20, -1);
    while (g < 200) begin
      @(negedge clk_125);
      g++;
      if (!tx_busy) break;
      n_busy++;
    end
    n_cmp++;
    if (n_busy !== IFG) begin n_bad++; $display("FAIL unf_ifg_slots: got %0d want %0d", n_busy, IFG); end
    wait_obs(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL unf_timeout: got %0d slots want %0d", obs_q.size(), exp_q.size()); end
    else begin
      for (int k = 0; exp_q.size() > 0; k++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL unf_slot%0d: got %h want %h", k, o, e); end
      end
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        if (o.dv || o.er || o.done) n_dv++;
      end
      n_cmp++;
      if (n_dv !== 0) begin n_bad++; $display("FAIL unf_after_drain: got %0d active slots want 0", n_dv); end
    end
    cap = 1'b0;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    bit ok; rec_t e, o;
    start_capture();
    push_frame(20, 8'h40, 1'b0);
    push_frame(61, 8'h80, 1'b1);
    send_frame(20, 8'h40, 1'b0, -1, -1);
    send_frame(61, 8'h80, 1'b1, -1, -1);
    wait_obs(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL b2b_timeout: got %0d slots want %0d", obs_q.size(), exp_q.size()); end
    else for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL b2b_slot%0d: got %h want %h", k, o, e); end
    end
    cap = 1'b0;
    wait_idle();
  endtask

  task automatic test_mid_reset();
    bit ok; rec_t e, o;
    send_frame(100, 8'h10, 1'b0, -1, 30);
    reset_n = 1'b0;
    @(posedge clk_125);
    @(negedge clk_125);
    n_cmp++; if (rgmii_mac_tx_dv !== 1'b0) begin n_bad++; $display("FAIL mrst_dv: got %b want 0", rgmii_mac_tx_dv); end
    n_cmp++; if (rgmii_mac_tx_er !== 1'b0) begin n_bad++; $display("FAIL mrst_er: got %b want 0", rgmii_mac_tx_er); end
    n_cmp++; if (s_tx_tready !== 1'b0) begin n_bad++; $display("FAIL mrst_tready: got %b want 0", s_tx_tready); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL mrst_busy: got %b want 0", tx_busy); end
    @(posedge clk_125); #1;
    reset_n = 1'b1;
    @(posedge clk_125); #1;
    start_capture();
    push_frame(60, 8'h20, 1'b0);
    send_frame(60, 8'h20, 1'b0, -1, -1);
    wait_obs(exp_q.size(), ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL mrst_timeout: got %0d slots want %0d", obs_q.size(), exp_q.size()); end
    else for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL mrst_slot%0d: got %h want %h", k, o, e); end
    end
    cap = 1'b0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_frame60();
    test_pad();
    test_slow();
    test_underrun();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
